// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUsel opcodes, FSM state encoding and opcode helpers.
// Used by iter_alu, ALU_control and the control-unit decode.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_BR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Operand/result handshake bundle between the sequencing logic and iter_alu.
// The master issues operations and takes results; the slave is the ALU.
interface iter_alu_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow, busy
    );

endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed overflow.
// On subtract, carry=1 means no borrow (a >= b unsigned).
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_full;

    assign w_b      = sub ? ~b : b;
    assign w_full   = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
    assign sum      = w_full[WIDTH-1:0];
    assign carry    = w_full[WIDTH];
    assign overflow = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/iter_alu.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, iterative one-bit-per-cycle
// shifter, registered result and flags behind a valid/ready handshake.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    iter_alu_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       r_state;
    alu_state_t       w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_negative;
    logic             r_carry;
    logic             r_overflow;

    logic             w_accept;
    logic             w_load_result;
    logic             w_load_shift;
    logic             w_shift_done;
    logic [SHW-1:0]   w_shamt;
    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_c;
    logic             w_add_v;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_shifted;

    assign w_shamt = bus.b[SHW-1:0];
    assign w_sub   = (bus.alu_sel != ALU_ADD);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (bus.a),
        .b        (bus.b),
        .sub      (w_sub),
        .sum      (w_sum),
        .carry    (w_add_c),
        .overflow (w_add_v)
    );

    // Single-cycle result; a shift op lands here only with shamt 0, where result = a.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.alu_sel)
            ALU_ADD, ALU_SUB, ALU_BR: begin
                w_res = w_sum;
                w_c   = w_add_c;
                w_v   = w_add_v;
            end
            ALU_OR:                   w_res = bus.a | bus.b;
            ALU_AND:                  w_res = bus.a & bus.b;
            ALU_XOR:                  w_res = bus.a ^ bus.b;
            ALU_SLT:                  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_v};
            ALU_SLTU:                 w_res = {{(WIDTH-1){1'b0}}, ~w_add_c};
            ALU_SLL, ALU_SRL, ALU_SRA: w_res = bus.a;
            default:                  w_res = '0;
        endcase
    end

    always_comb begin
        case (r_op)
            ALU_SLL: w_shifted = {r_acc[WIDTH-2:0], 1'b0};
            ALU_SRA: w_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            default: w_shifted = {1'b0, r_acc[WIDTH-1:1]};
        endcase
    end

    // in_ready is combinational so DONE can hand over to a new op in the same cycle.
    assign bus.in_ready = !rst && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_accept     = bus.in_ready && bus.in_valid;

    always_comb begin
        w_next_state  = r_state;
        w_load_result = 1'b0;
        w_load_shift  = 1'b0;
        w_shift_done  = 1'b0;
        case (r_state)
            IDLE:    w_next_state = IDLE;
            SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_shift_done = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (w_accept) begin
            if (is_shift(bus.alu_sel) && (w_shamt != '0)) begin
                w_load_shift = 1'b1;
                w_next_state = SHIFT;
            end else begin
                w_load_result = 1'b1;
                w_next_state  = DONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_op       <= ALU_ADD;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load_result) begin
                r_result   <= w_res;
                r_zero     <= (w_res == '0);
                r_negative <= w_res[WIDTH-1];
                r_carry    <= w_c;
                r_overflow <= w_v;
            end
            if (w_load_shift) begin
                r_acc <= bus.a;
                r_cnt <= w_shamt;
                r_op  <= bus.alu_sel;
            end
            if (r_state == SHIFT) begin
                r_acc <= w_shifted;
                r_cnt <= r_cnt - SHW'(1);
                if (w_shift_done) begin
                    r_result   <= w_shifted;
                    r_zero     <= (w_shifted == '0);
                    r_negative <= w_shifted[WIDTH-1];
                    r_carry    <= 1'b0;
                    r_overflow <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == SHIFT);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu: hand-computed vectors, latency,
// backpressure, back-to-back issue and asynchronous reset mid-shift.
module tb_iter_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   lat;
    int   bcnt;

    always #5 clk = ~clk;

    iter_alu_if #(.WIDTH(32)) bus ();

    iter_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res,
                           input logic z, input logic n, input logic c, input logic v);
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, " result"},    bus.result, res);
        check({tag, " zero"},      {31'd0, bus.zero},     {31'd0, z});
        check({tag, " negative"},  {31'd0, bus.negative}, {31'd0, n});
        check({tag, " carry"},     {31'd0, bus.carry},    {31'd0, c});
        check({tag, " overflow"},  {31'd0, bus.overflow}, {31'd0, v});
    endtask

    // Drive one op at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input string tag, input logic [3:0] sel,
                        input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        bus.alu_sel  = sel;
        bus.a        = aa;
        bus.b        = bb;
        bus.in_valid = 1'b1;
        #1 check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l, output int bc);
        l  = 1;
        bc = 0;
        while (bus.out_valid !== 1'b1 && l < 100) begin
            if (bus.busy === 1'b1) bc++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] sel,
                       input logic [31:0] aa, input logic [31:0] bb, input int exp_lat,
                       input logic [31:0] res, input logic z, input logic n,
                       input logic c, input logic v);
        int l;
        int bc;
        send(tag, sel, aa, bb);
        wait_done(l, bc);
        check({tag, " latency"}, l, exp_lat);
        chk_out(tag, res, z, n, c, v);
        take();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_sel   = ALU_ADD;
        bus.out_ready = 1'b0;

        #12;
        check("rst in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst busy",      {31'd0, bus.busy},      32'd0);
        check("rst result",    bus.result,             32'd0);
        check("rst flags",     {28'd0, bus.zero, bus.negative, bus.carry, bus.overflow}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1 check("idle in_ready", {31'd0, bus.in_ready}, 32'd1);

        run("add",      ALU_ADD,  32'd5,        32'd7,  1, 32'd12,       0, 0, 0, 0);
        run("sub neg",  ALU_SUB,  32'd3,        32'd5,  1, 32'hFFFFFFFE, 0, 1, 0, 0);
        run("sub eq",   ALU_SUB,  32'd9,        32'd9,  1, 32'd0,        1, 0, 1, 0);
        run("add ovf",  ALU_ADD,  32'h7FFFFFFF, 32'd1,  1, 32'h80000000, 0, 1, 0, 1);
        run("add wrap", ALU_ADD,  32'hFFFFFFFF, 32'd1,  1, 32'd0,        1, 0, 1, 0);
        run("branch",   ALU_BR,   32'd5,        32'd3,  1, 32'd2,        0, 0, 1, 0);
        run("or",       ALU_OR,   32'hF0,       32'h0F, 1, 32'hFF,       0, 0, 0, 0);
        run("and",      ALU_AND,  32'hFF,       32'h0F, 1, 32'h0F,       0, 0, 0, 0);
        run("slt",      ALU_SLT,  32'hFFFFFFFF, 32'd1,  1, 32'd1,        0, 0, 0, 0);
        run("sltu",     ALU_SLTU, 32'hFFFFFFFF, 32'd1,  1, 32'd0,        1, 0, 0, 0);
        run("badop",    4'b0010,  32'd5,        32'd6,  1, 32'd0,        1, 0, 0, 0);
        run("sll0",     ALU_SLL,  32'd1,        32'd0,  1, 32'd1,        0, 0, 0, 0);
        run("sll mask", ALU_SLL,  32'd1,        32'h24, 5, 32'd16,       0, 0, 0, 0);
        run("srl31",    ALU_SRL,  32'h80000000, 32'd31, 32, 32'd1,       0, 0, 0, 0);

        // SRA with conflicting inputs offered while shifting; they must be ignored.
        send("sra", ALU_SRA, 32'h80000000, 32'd4);
        bus.in_valid = 1'b1;
        bus.alu_sel  = ALU_ADD;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        #1 check("sra in_ready", {31'd0, bus.in_ready}, 32'd0);
        wait_done(lat, bcnt);
        bus.in_valid = 1'b0;
        check("sra latency", lat, 32'd5);
        check("sra busy cycles", bcnt, 32'd4);
        chk_out("sra", 32'hF8000000, 0, 1, 0, 0);
        take();

        // Backpressure on XOR, then back-to-back ADDs with out_ready held high.
        send("xor", ALU_XOR, 32'hAAAA0000, 32'h0000FFFF);
        wait_done(lat, bcnt);
        check("xor latency", lat, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out("xor hold", 32'hAAAAFFFF, 0, 1, 0, 0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alu_sel   = ALU_ADD;
        bus.a         = 32'd2;
        bus.b         = 32'd3;
        #1 check("b2b in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        chk_out("b2b add", 32'd5, 0, 0, 0, 0);
        bus.a = 32'd10;
        bus.b = 32'd20;
        @(negedge clk);
        chk_out("b2b add2", 32'd30, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b drained", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of a long shift.
        send("sll20", ALU_SLL, 32'd1, 32'd20);
        repeat (3) @(negedge clk);
        check("sll20 busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid rst result",    bus.result,             32'd0);
        check("mid rst busy",      {31'd0, bus.busy},      32'd0);
        check("mid rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid rst in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("mid rst flags",     {28'd0, bus.zero, bus.negative, bus.carry, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("post rst add", ALU_ADD, 32'd2, 32'd2, 1, 32'd4, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
